// File: rtl/onehot_encoder_jogada_if.sv
// rtl/onehot_encoder_jogada_if.sv - button/index handshake bundle between board pins and game datapath
interface onehot_encoder_jogada_if;
  logic       enable;
  logic [7:0] botoes;
  logic [2:0] codigo;
  logic       jogada_valida;
  logic       jogada_invalida;
  logic       ocupado;

  modport master (
    output enable, botoes,
    input  codigo, jogada_valida, jogada_invalida, ocupado
  );

  modport slave (
    input  enable, botoes,
    output codigo, jogada_valida, jogada_invalida, ocupado
  );
endinterface

// File: rtl/onehot_encoder_jogada.sv
// rtl/onehot_encoder_jogada.sv - debounced 8-button to 3-bit index encoder with release-triggered pulse
// Optional macro ONEHOT_ENCODER_PRIORITY_EN: multi-button presses resolve to the lowest set bit.
module onehot_encoder_jogada #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input logic                    clock,
  input logic                    reset,
  onehot_encoder_jogada_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, EMIT} state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       s;
  logic [7:0]       captured;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       codigo_q;
  logic [2:0]       idx;
  logic             emit_ok;

  // Lowest-index set bit; for a one-hot vector this is simply its index.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (captured[i]) idx = 3'(i);
    end
  end

`ifdef ONEHOT_ENCODER_PRIORITY_EN
  assign emit_ok             = (captured != 8'd0);
  assign bus.jogada_valida   = (state == EMIT) && emit_ok;
  assign bus.jogada_invalida = 1'b0;
`else
  logic is_onehot;
  assign is_onehot           = (captured != 8'd0) && ((captured & (captured - 8'd1)) == 8'd0);
  assign emit_ok             = is_onehot;
  assign bus.jogada_valida   = (state == EMIT) && is_onehot;
  assign bus.jogada_invalida = (state == EMIT) && !is_onehot;
`endif

  assign bus.codigo  = codigo_q;
  assign bus.ocupado = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.enable && (s != 8'd0)) state_next = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (s != captured)                              state_next = IDLE;
        else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1))    state_next = HELD;
      end
      HELD: begin
        if (s == 8'd0) state_next = EMIT;
      end
      EMIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s        <= 8'd0;
      state    <= IDLE;
      captured <= 8'd0;
      cnt      <= '0;
      codigo_q <= 3'd0;
    end else begin
      s     <= bus.botoes;
      state <= state_next;
      if ((state == IDLE) && (state_next == DEBOUNCE)) begin
        captured <= s;
        cnt      <= '0;
      end
      if ((state == DEBOUNCE) && (state_next == DEBOUNCE)) cnt <= cnt + 1'b1;
      // codigo is loaded on the HELD->EMIT edge so it is valid alongside the pulse.
      if ((state == HELD) && (state_next == EMIT) && emit_ok) codigo_q <= idx;
    end
  end

endmodule

// File: tb/tb_onehot_encoder_jogada.sv
// tb/tb_onehot_encoder_jogada.sv - directed bench for onehot_encoder_jogada
module tb_onehot_encoder_jogada;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  int   n_invalid = 0;
  int   n_both = 0;

  onehot_encoder_jogada_if bus ();

  onehot_encoder_jogada #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.jogada_valida) n_valid++;
    if (bus.jogada_invalida) n_invalid++;
    if (bus.jogada_valida && bus.jogada_invalida) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press_release(input logic [7:0] val, input int width, input int post);
    bus.botoes = val;
    tick(width);
    bus.botoes = 8'h00;
    tick(post);
  endtask

  int v0, i0;
  logic [2:0] exp_multi_code;
  logic       exp_multi_valid;

  initial begin
    bus.enable = 1'b1;
    bus.botoes = 8'h00;
    tick(2);
    reset = 1'b0;

    // idle after reset: {codigo, valida, invalida, ocupado} all zero
    for (int i = 0; i < 20; i++) begin
      check("idle_outputs", {bus.codigo, bus.jogada_valida, bus.jogada_invalida, bus.ocupado}, 32'h0);
    end
    tick(20);
    check("idle_outputs_end", {bus.codigo, bus.jogada_valida, bus.jogada_invalida, bus.ocupado}, 32'h0);

    // single press 0x20, exact release latency
    v0 = n_valid; i0 = n_invalid;
    bus.botoes = 8'h20;
    tick(10);
    check("press20_ocupado", bus.ocupado, 1);
    bus.botoes = 8'h00;
    tick(1);
    check("press20_r_valid", bus.jogada_valida, 0);
    tick(1);
    check("press20_r1_valid", bus.jogada_valida, 1);
    check("press20_r1_codigo", bus.codigo, 5);
    tick(1);
    check("press20_r2_valid", bus.jogada_valida, 0);
    check("press20_r2_ocupado", bus.ocupado, 0);
    tick(5);
    check("press20_pulses", n_valid - v0, 1);
    check("press20_invalid", n_invalid - i0, 0);
    check("press20_codigo_held", bus.codigo, 5);

    // bounce: glitch to 0 during debounce aborts, then new capture
    v0 = n_valid;
    bus.botoes = 8'h04;
    tick(3);
    bus.botoes = 8'h00;
    tick(1);
    bus.botoes = 8'h04;
    tick(1);
    check("bounce_abort_idle", bus.ocupado, 0);
    tick(9);
    bus.botoes = 8'h00;
    tick(6);
    check("bounce_pulses", n_valid - v0, 1);
    check("bounce_codigo", bus.codigo, 2);

    // multi-button press
`ifdef ONEHOT_ENCODER_PRIORITY_EN
    exp_multi_code  = 3'd0;
    exp_multi_valid = 1'b1;
`else
    exp_multi_code  = 3'd2;
    exp_multi_valid = 1'b0;
`endif
    v0 = n_valid; i0 = n_invalid;
    press_release(8'h11, 10, 6);
    check("multi_valid", n_valid - v0, exp_multi_valid ? 1 : 0);
    check("multi_invalid", n_invalid - i0, exp_multi_valid ? 0 : 1);
    check("multi_codigo", bus.codigo, exp_multi_code);

    // press width boundary: DEBOUNCE_CYCLES rejected, DEBOUNCE_CYCLES+1 accepted
    v0 = n_valid; i0 = n_invalid;
    press_release(8'h40, 4, 8);
    check("width4_pulses", (n_valid - v0) + (n_invalid - i0), 0);
    check("width4_codigo", bus.codigo, exp_multi_code);
    v0 = n_valid;
    press_release(8'h08, 5, 8);
    check("width5_pulses", n_valid - v0, 1);
    check("width5_codigo", bus.codigo, 3);

    // enable=0 in IDLE ignores buttons
    v0 = n_valid; i0 = n_invalid;
    bus.enable = 1'b0;
    bus.botoes = 8'h80;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("gated_ocupado", bus.ocupado, 0);
    end
    bus.botoes = 8'h00;
    tick(6);
    check("gated_pulses", (n_valid - v0) + (n_invalid - i0), 0);
    bus.enable = 1'b1;

    // reset while HELD, release together with reset
    v0 = n_valid; i0 = n_invalid;
    bus.botoes = 8'h80;
    tick(10);
    check("rst_held_ocupado", bus.ocupado, 1);
    reset = 1'b1;
    bus.botoes = 8'h00;
    tick(1);
    check("rst_ocupado", bus.ocupado, 0);
    check("rst_codigo", bus.codigo, 0);
    reset = 1'b0;
    tick(10);
    check("rst_pulses", (n_valid - v0) + (n_invalid - i0), 0);
    check("rst_codigo_after", bus.codigo, 0);

    // completed emission, then long hold with enable dropped mid-press
    v0 = n_valid;
    press_release(8'h02, 8, 6);
    check("hold_first_pulse", n_valid - v0, 1);
    v0 = n_valid;
    bus.botoes = 8'h02;
    tick(10);
    bus.enable = 1'b0;
    tick(40);
    check("hold_no_pulse", n_valid - v0, 0);
    check("hold_ocupado", bus.ocupado, 1);
    bus.botoes = 8'h00;
    tick(6);
    check("hold_release_pulse", n_valid - v0, 1);
    check("hold_codigo", bus.codigo, 1);
    bus.enable = 1'b1;

    check("never_both", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
